// File: rtl/cmd_link_pkg.sv
// ---------------------------------------------------------------------------
// cmd_link_pkg
//   Shared definitions for the host command link. Contains the default sync
//   bytes, the frame parser state encoding and a helper that turns a payload
//   length in bytes into the command word width.
// ---------------------------------------------------------------------------
package cmd_link_pkg;

   // Default two-byte sync pattern that opens every command frame.
   localparam logic [7:0] HDR0_DEFAULT = 8'hEB;
   localparam logic [7:0] HDR1_DEFAULT = 8'h90;

   // Frame parser states.
   typedef enum logic [1:0] {
      S_HDR0    = 2'd0,
      S_HDR1    = 2'd1,
      S_PAYLOAD = 2'd2,
      S_CHK     = 2'd3
   } parser_state_t;

   // Command word width for a given payload length.
   function automatic int width_of(input int payload_bytes);
      return 8 * payload_bytes;
   endfunction

endpackage

// File: rtl/cmd_frame_parser.sv
// ---------------------------------------------------------------------------
// cmd_frame_parser
//   Byte-level framing for the host command link. Hunts for the two sync
//   bytes, assembles PAYLOAD_BYTES payload bytes (first byte lands in the
//   MSB), and checks the trailing XOR checksum. A frame is abandoned when
//   the line stays idle for TIMEOUT_CYCLES cycles inside a frame.
//
// Ports
//   clk         in   system clock
//   rst         in   asynchronous reset, active-low
//   rx_data     in   received byte, qualified by rx_valid
//   rx_valid    in   one-cycle strobe per received byte
//   frame_done  out  combinational pulse in the cycle a checksum byte matches
//   frame_word  out  assembled payload, valid while frame_done is high
//   frame_err   out  combinational pulse on checksum mismatch or timeout
// ---------------------------------------------------------------------------
module cmd_frame_parser
   import cmd_link_pkg::*;
#(
   parameter int          PAYLOAD_BYTES  = 4,
   parameter logic [7:0]  HDR0           = HDR0_DEFAULT,
   parameter logic [7:0]  HDR1           = HDR1_DEFAULT,
   parameter int          TIMEOUT_CYCLES = 50000,
   localparam int         W              = width_of(PAYLOAD_BYTES)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   rx_data,
   input  logic         rx_valid,
   output logic         frame_done,
   output logic [W-1:0] frame_word,
   output logic         frame_err
);

   localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
   localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PAYLOAD_BYTES - 1);
   // The idle cycle that would make the gap reach TIMEOUT_CYCLES aborts the frame.
   localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYCLES - 1);

   parser_state_t    state_q, state_d;
   logic [IDX_W-1:0] idx_q,   idx_d;
   logic [7:0]       chk_q,   chk_d;
   logic [W-1:0]     word_q,  word_d;
   logic [GAP_W-1:0] gap_q,   gap_d;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can
      // leave a signal unassigned and infer a latch.
      state_d    = state_q;
      idx_d      = idx_q;
      chk_d      = chk_q;
      word_d     = word_q;
      gap_d      = gap_q;
      frame_done = 1'b0;
      frame_err  = 1'b0;

      if (rx_valid) begin
         gap_d = '0;
         case (state_q)
            S_HDR0: begin
               if (rx_data == HDR0) state_d = S_HDR1;
            end
            S_HDR1: begin
               if (rx_data == HDR1) begin
                  state_d = S_PAYLOAD;
                  idx_d   = '0;
                  chk_d   = '0;
               end else if (rx_data != HDR0) begin
                  // A repeated HDR0 keeps us here so "EB EB 90" still syncs.
                  state_d = S_HDR0;
               end
            end
            S_PAYLOAD: begin
               word_d = (word_q << 8) | W'(rx_data);
               chk_d  = chk_q ^ rx_data;
               idx_d  = idx_q + IDX_W'(1);
               if (idx_q == LAST_IDX) state_d = S_CHK;
            end
            S_CHK: begin
               if (rx_data == chk_q) frame_done = 1'b1;
               else                  frame_err  = 1'b1;
               state_d = S_HDR0;
            end
            default: state_d = S_HDR0;
         endcase
      end else if (state_q != S_HDR0) begin
         if (gap_q == GAP_LIMIT) begin
            state_d   = S_HDR0;
            gap_d     = '0;
            frame_err = 1'b1;
         end else begin
            gap_d = gap_q + GAP_W'(1);
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_HDR0;
         idx_q   <= '0;
         chk_q   <= '0;
         word_q  <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         chk_q   <= chk_d;
         word_q  <= word_d;
         gap_q   <= gap_d;
      end
   end

   // By the checksum byte the shift register holds exactly one full payload.
   assign frame_word = word_q;

endmodule

// File: rtl/cmd_receiver.sv
// ---------------------------------------------------------------------------
// cmd_receiver
//   Producer side of the cmd_ready / cmd_ready_clear handshake. Validated
//   frames from cmd_frame_parser land in a pending register and raise
//   cmd_ready; an acknowledge from the consumer promotes pending to the
//   active command that drives the synth/RF control path.
//
// Ports
//   clk               in   system clock
//   rst               in   asynchronous reset, active-low
//   rx_data           in   received byte, qualified by rx_valid
//   rx_valid          in   one-cycle strobe per received byte
//   cmd_ready_clear   in   consumer acknowledge, one-cycle pulse
//   cmd_ready         out  pending command available
//   cmd_pending       out  most recent validated command
//   cmd_active        out  command currently applied to hardware
//   cmd_active_valid  out  set once any command has been promoted
//   frame_err         out  registered pulse: bad checksum or timeout
//   overrun           out  registered pulse: pending overwritten unacknowledged
//   err_count         out  saturating count of frame_err pulses
// ---------------------------------------------------------------------------
module cmd_receiver
   import cmd_link_pkg::*;
#(
   parameter int          PAYLOAD_BYTES  = 4,
   parameter logic [7:0]  HDR0           = HDR0_DEFAULT,
   parameter logic [7:0]  HDR1           = HDR1_DEFAULT,
   parameter int          TIMEOUT_CYCLES = 50000,
   localparam int         W              = width_of(PAYLOAD_BYTES)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   rx_data,
   input  logic         rx_valid,
   input  logic         cmd_ready_clear,
   output logic         cmd_ready,
   output logic [W-1:0] cmd_pending,
   output logic [W-1:0] cmd_active,
   output logic         cmd_active_valid,
   output logic         frame_err,
   output logic         overrun,
   output logic [7:0]   err_count
);

   logic         frame_done;
   logic [W-1:0] frame_word;
   logic         parse_err;

   cmd_frame_parser #(
      .PAYLOAD_BYTES  (PAYLOAD_BYTES),
      .HDR0           (HDR0),
      .HDR1           (HDR1),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_parser (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .frame_done (frame_done),
      .frame_word (frame_word),
      .frame_err  (parse_err)
   );

   logic         ready_q,        ready_d;
   logic [W-1:0] pending_q,      pending_d;
   logic [W-1:0] active_q,       active_d;
   logic         active_valid_q, active_valid_d;
   logic         frame_err_q,    frame_err_d;
   logic         overrun_q,      overrun_d;
   logic [7:0]   err_count_q,    err_count_d;

   logic         clear_fire;

   always_comb begin
      ready_d        = ready_q;
      pending_d      = pending_q;
      active_d       = active_q;
      active_valid_d = active_valid_q;
      frame_err_d    = parse_err;
      overrun_d      = 1'b0;
      err_count_d    = err_count_q;

      // An acknowledge only counts while something is pending.
      clear_fire = cmd_ready_clear && ready_q;

      // Promotion reads the old pending value, so a commit in the same cycle
      // hands the previous command to the active side and keeps the new one.
      if (clear_fire) begin
         active_d       = pending_q;
         active_valid_d = 1'b1;
         ready_d        = 1'b0;
      end

      if (frame_done) begin
         pending_d = frame_word;
         ready_d   = 1'b1;
         overrun_d = ready_q && !clear_fire;
      end

      if (parse_err && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ready_q        <= 1'b0;
         pending_q      <= '0;
         active_q       <= '0;
         active_valid_q <= 1'b0;
         frame_err_q    <= 1'b0;
         overrun_q      <= 1'b0;
         err_count_q    <= '0;
      end else begin
         ready_q        <= ready_d;
         pending_q      <= pending_d;
         active_q       <= active_d;
         active_valid_q <= active_valid_d;
         frame_err_q    <= frame_err_d;
         overrun_q      <= overrun_d;
         err_count_q    <= err_count_d;
      end
   end

   assign cmd_ready        = ready_q;
   assign cmd_pending      = pending_q;
   assign cmd_active       = active_q;
   assign cmd_active_valid = active_valid_q;
   assign frame_err        = frame_err_q;
   assign overrun          = overrun_q;
   assign err_count        = err_count_q;

endmodule
